// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package : alu_pkg
// Brief   : Shared ALU widths, opcodes and sequencer FSM encoding.
// Rev     : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_DW  = 32;
    localparam int ALU_OPW = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_MOD = 3'b100;
    localparam logic [2:0] OP_POW = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_cmd_sequencer_if
// Brief     : Command and result valid/ready channels of the ALU sequencer.
// Rev       : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
);
    logic           cmd_valid;
    logic           cmd_ready;
    logic [DW-1:0]  cmd_a;
    logic [DW-1:0]  cmd_b;
    logic [OPW-1:0] cmd_op;
    logic           cmd_chain;

    logic           res_valid;
    logic           res_ready;
    logic [DW-1:0]  res_data;
    logic [OPW-1:0] res_op;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
        output cmd_ready, res_valid, res_data, res_op
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, res_ready,
        input  cmd_ready, res_valid, res_data, res_op
    );

endinterface
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module : alu
// Brief  : Combinational ALU (add/sub/mul/div/mod/pow); divide by zero gives 0.
// Rev    : 1.0 - initial release
// ============================================================================
module alu
    import alu_pkg::*;
#(
    parameter int DW  = ALU_DW,
    parameter int OPW = ALU_OPW
) (
    input  wire logic [DW-1:0]  a,
    input  wire logic [DW-1:0]  b,
    input  wire logic [OPW-1:0] cs,
    output logic      [DW-1:0]  y
);

    logic [DW-1:0] pow_acc;
    logic [DW-1:0] pow_base;

    // Square-and-multiply, truncated to DW bits.
    always_comb begin
        pow_acc  = {{(DW-1){1'b0}}, 1'b1};
        pow_base = a;
        for (int i = 0; i < DW; i++) begin
            if (b[i]) begin
                pow_acc = pow_acc * pow_base;
            end
            pow_base = pow_base * pow_base;
        end
    end

    always_comb begin
        y = '0;
        case (cs)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_MUL:  y = a * b;
            OP_DIV:  y = (b == '0) ? '0 : a / b;
            OP_MOD:  y = (b == '0) ? '0 : a % b;
            OP_POW:  y = pow_acc;
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module : alu_cmd_fifo
// Brief  : Synchronous command FIFO with registered occupancy count.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int WIDTH = 2*ALU_DW + ALU_OPW + 1,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           wdata,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           rdata,
    output logic      [$clog2(DEPTH+1)-1:0] count,
    output logic                            full,
    output logic                            empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module : alu_cmd_sequencer
// Brief  : Queues ALU commands, drives registered operands, samples y after
//          SETTLE cycles and returns it over a valid/ready result channel.
// Rev    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DW     = ALU_DW,
    parameter int OPW    = ALU_OPW,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    alu_cmd_sequencer_if.slave              bus,
    output logic      [DW-1:0]              alu_a,
    output logic      [DW-1:0]              alu_b,
    output logic      [OPW-1:0]             alu_cs,
    input  wire logic [DW-1:0]              alu_y,
    output logic                            busy,
    output logic      [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int CMD_W = 2*DW + OPW + 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    alu_a_q, alu_a_d;
    logic [DW-1:0]    alu_b_q, alu_b_d;
    logic [OPW-1:0]   alu_cs_q, alu_cs_d;
    logic [DW-1:0]    res_data_q, res_data_d;
    logic [OPW-1:0]   res_op_q, res_op_d;
    logic             res_valid_q, res_valid_d;
    logic [DW-1:0]    last_result_q, last_result_d;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             load;
    logic             capture;

    assign bus.cmd_ready = !fifo_full;
    assign fifo_push     = bus.cmd_valid && !fifo_full;
    assign fifo_wdata    = {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_chain};

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A new command is loaded from IDLE, or straight out of HOLD on the accepting edge.
    assign load    = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.res_ready));
    assign capture = (state_q == ST_SETTLE) && (cnt_q == CNT_LAST);
    assign fifo_pop = load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_cs_q      <= '0;
            res_data_q    <= '0;
            res_op_q      <= '0;
            res_valid_q   <= 1'b0;
            last_result_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_cs_q      <= alu_cs_d;
            res_data_q    <= res_data_d;
            res_op_q      <= res_op_d;
            res_valid_q   <= res_valid_d;
            last_result_q <= last_result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_SETTLE;
            ST_SETTLE: if (capture)     state_d = ST_HOLD;
            ST_HOLD:   if (bus.res_ready) state_d = fifo_empty ? ST_IDLE : ST_SETTLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_cs_d      = alu_cs_q;
        res_data_d    = res_data_q;
        res_op_d      = res_op_q;
        res_valid_d   = res_valid_q;
        last_result_d = last_result_q;

        if (load) begin
            alu_a_d  = fifo_rdata[0] ? last_result_q : fifo_rdata[CMD_W-1 -: DW];
            alu_b_d  = fifo_rdata[OPW+1 +: DW];
            alu_cs_d = fifo_rdata[1 +: OPW];
            cnt_d    = '0;
        end

        if (state_q == ST_SETTLE) begin
            if (capture) begin
                res_data_d    = alu_y;
                res_op_d      = alu_cs_q;
                last_result_d = alu_y;
                res_valid_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if ((state_q == ST_HOLD) && bus.res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_cs        = alu_cs_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_op    = res_op_q;
    assign busy          = (state_q != ST_IDLE) || (fifo_count != '0);

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Upstream issue stage for the combinational 32-bit `alu` (ports a, b, cs → y).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives registered a/b/cs into the ALU, holds them for a programmable number of settle cycles, then captures y and presents it over a valid/ready result interface.
- Supports chaining: the previous result can be used as operand a.

Parameters:
- DW, 32, operand/result width; must match the `alu` width.
- OPW, 3, opcode width (`alu` cs).
- DEPTH, 4, command FIFO entries; power of two, ≥2.
- SETTLE, 2, cycles ALU inputs are held before y is sampled; ≥1. Sized for the pow/div paths.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_a  in  DW  operand a.
- cmd_b  in  DW  operand b.
- cmd_op  in  OPW  opcode, forwarded to alu cs.
- cmd_chain  in  1  1 = use last captured result as operand a; cmd_a is ignored.
- alu_a  out  DW  to alu a (registered).
- alu_b  out  DW  to alu b (registered).
- alu_cs  out  OPW  to alu cs (registered).
- alu_y  in  DW  from alu y.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  DW  captured result.
- res_op  out  OPW  opcode that produced res_data.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - All outputs go to 0; cmd_ready is 1 after release.
  - FIFO is emptied, last_result=0, FSM=IDLE, settle counter=0.
  - Reset mid-operation discards queued and in-flight commands; a pending res_valid drops immediately.
- FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready = (fifo_count<DEPTH), purely from the registered count.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle; no fall-through.
  - Push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - A command is stored with {a,b,op,chain}.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: if FIFO non-empty, pop the head and load alu_a/alu_b/alu_cs. alu_a = last_result if chain, else cmd_a. Set cnt=0 and go to SETTLE. Otherwise stay in IDLE; ALU regs keep their last values.
  - SETTLE: if cnt==SETTLE-1, capture res_data<=alu_y and res_op<=alu_cs, set last_result<=alu_y and res_valid<=1, then go to HOLD. Otherwise cnt++.
  - HOLD: res_valid, res_data and res_op stay stable until res_ready=1.
  - On the accepting edge res_valid<=0. If the FIFO is non-empty, pop and load the next command (go to SETTLE); otherwise go to IDLE.
- Latency:
  - A push into an empty FIFO at edge E0 gives: load at E1, res_valid high after edge E(1+SETTLE). With SETTLE=2 that is after E3.
  - Back-to-back throughput with res_ready tied to 1 is one result per SETTLE+1 cycles.
- Chain: last_result is read at load time, so it is the result of the immediately preceding executed command. Chain with no prior result since reset uses 0.
- Opcodes are not interpreted; 110/111 pass through unchanged.
- busy = (state!=IDLE) || (fifo_count!=0).

Decomposition:
- Shared package `alu_pkg`:
  - Opcode constants: OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011, OP_MOD=3'b100, OP_POW=3'b101.
  - DW and OPW defaults.
  - FSM state encoding.
- Sub-module `alu_cmd_fifo`:
  - Synchronous FIFO with parameters WIDTH=2*DW+OPW+1 and DEPTH.
  - Outputs count, full and empty.
  - Instantiated once.
- The bench instantiates the real `alu` on alu_a/alu_b/alu_cs/alu_y.

Test Plan:
- Single op: push a=15, b=3, op=OP_MUL with res_ready=1 → res_valid rises after the 3rd edge following the push; res_data=45, res_op=010, pulse one cycle, busy returns to 0.
- Burst of five: push (15,3) with SUB, DIV, POW, MOD, and ADD opcodes, res_ready=1 → results in order 12, 5, 3375, 0, 18; one result every 3 cycles.
- Chain: (15,3,MUL), then chain=1 with b=5, SUB → results 45, then 40; alu_a=45 during the second op.
- Backpressure/full: hold res_ready=0 and push 6 commands → cmd_ready=0 once fifo_count=4. res_data stays stable in HOLD; the 6th cmd_valid is stalled. Release res_ready → all results drain in order with none lost or duplicated.
- Reset mid-op: assert rst_n=0 during SETTLE with 2 commands queued → res_valid, alu_a, alu_b, alu_cs and fifo_count go to 0 immediately. After release, an idle FIFO produces no output; a new (15,3,SUB) yields 12.
- Chain after reset: first command chain=1, b=3, ADD → result 3, since last_result=0.
